// File: rtl/rst_sequencer.sv
// Staggered reset sequencer: synchronises button and lock inputs, then releases
// one reset per domain in order. Optional button debounce via RST_SEQ_DEBOUNCE_EN.
module rst_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int NUM_LOCKS       = 2,
  parameter int NUM_DOMAINS     = 3,
  parameter int PULSE_CYCLES    = 16,
  parameter int STAGGER_CYCLES  = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_in,
  input  logic [NUM_LOCKS-1:0]   locks,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   busy
);

  localparam int LAST     = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int REL_SPAN = LAST + 1;
  localparam int MAX_A    = (PULSE_CYCLES > REL_SPAN) ? PULSE_CYCLES : REL_SPAN;
  localparam int MAXV     = (MAX_A > DEBOUNCE_CYCLES) ? MAX_A : DEBOUNCE_CYCLES;
  localparam int CW       = $clog2(MAXV) + 1;

  typedef enum logic [1:0] {ST_HOLD, ST_ASSERT, ST_RELEASE, ST_RUN} state_t;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [NUM_DOMAINS-1:0] rst_out_reg, rst_out_next;
  logic [NUM_DOMAINS-1:0] rel_mask;
  logic [NUM_LOCKS:0]     async_vec, sync_vec;
  logic                   locks_ok, btn_sync, press;

  assign async_vec = {btn_in, locks};

  genvar gi;
  generate
    for (gi = 0; gi <= NUM_LOCKS; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) chain_reg <= '0;
        else     chain_reg <= {chain_reg[SYNC_STAGES-2:0], async_vec[gi]};
      end
      assign sync_vec[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  assign locks_ok = &sync_vec[NUM_LOCKS-1:0];
  assign btn_sync = sync_vec[NUM_LOCKS];

`ifdef RST_SEQ_DEBOUNCE_EN
  // Count saturates at DEBOUNCE_CYCLES so a held button yields a single press.
  logic [CW-1:0] db_cnt_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    db_cnt_reg <= '0;
    else if (!btn_sync)                         db_cnt_reg <= '0;
    else if (db_cnt_reg != CW'(DEBOUNCE_CYCLES)) db_cnt_reg <= db_cnt_reg + 1'b1;
  end
  assign press = btn_sync && (db_cnt_reg == CW'(DEBOUNCE_CYCLES - 1));
`else
  logic btn_prev_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_prev_reg <= 1'b0;
    else     btn_prev_reg <= btn_sync;
  end
  assign press = btn_sync & ~btn_prev_reg;
`endif

  // Domain i stays in reset while the release count is below its threshold.
  generate
    for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_mask
      localparam int THR = gi * STAGGER_CYCLES;
      if (THR == 0) begin : g_zero
        assign rel_mask[gi] = 1'b0;
      end else begin : g_cmp
        assign rel_mask[gi] = (cnt_next < CW'(THR));
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (!locks_ok) begin
      state_next = ST_HOLD;
      cnt_next   = '0;
    end else if (press && (state_reg != ST_HOLD)) begin
      state_next = ST_ASSERT;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_HOLD: begin
          state_next = ST_ASSERT;
          cnt_next   = '0;
        end
        ST_ASSERT: begin
          if (cnt_reg == CW'(PULSE_CYCLES - 1)) begin
            cnt_next   = '0;
            state_next = (LAST == 0) ? ST_RUN : ST_RELEASE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_RELEASE: begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_next == CW'(LAST)) state_next = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rst_out_next = '1;
    if (state_next == ST_RUN)          rst_out_next = '0;
    else if (state_next == ST_RELEASE) rst_out_next = rel_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_HOLD;
      cnt_reg     <= '0;
      rst_out_reg <= '1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rst_out_reg <= rst_out_next;
    end
  end

  assign rst_out = rst_out_reg;
  assign busy    = |rst_out_reg;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: stimulus queues expected rst_out changes
// (edge, value); a negedge monitor pops and checks each observed change.
module tb_rst_sequencer;

`ifdef RST_SEQ_DEBOUNCE_EN
  localparam int PW = 12;  // button pulse width used for presses
  localparam int L  = 9;   // first-sample to ASSERT latency
`else
  localparam int PW = 1;
  localparam int L  = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic [1:0] locks = 2'b11;
  logic [2:0] rst_out;
  logic       busy;

  int edge_cnt = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int         e;
    logic [2:0] v;
  } ev_t;
  ev_t q[$];

  rst_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn_in),
    .locks   (locks),
    .rst_out (rst_out),
    .busy    (busy)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: every change of rst_out is a transaction checked against the queue.
  logic [2:0] last_seen = 3'b111;
  always @(negedge clk) begin
    if (rst) begin
      last_seen = rst_out;
    end else if (rst_out !== last_seen) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change edge=%0d rst_out=%b (no change expected)", edge_cnt, rst_out);
      end else begin
        ev_t ev;
        ev = q.pop_front();
        if (ev.e != edge_cnt || rst_out !== ev.v || busy !== (|ev.v)) begin
          bad++;
          $display("FAIL rst_change got edge=%0d rst_out=%b busy=%b want edge=%0d rst_out=%b busy=%b",
                   edge_cnt, rst_out, busy, ev.e, ev.v, |ev.v);
        end else begin
          $display("ok   rst_change edge=%0d rst_out=%b busy=%b", edge_cnt, rst_out, busy);
        end
      end
      last_seen = rst_out;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int e, input logic [2:0] v);
    ev_t ev;
    ev.e = e;
    ev.v = v;
    q.push_back(ev);
  endtask

  task automatic wait_until(input int e);
    while (edge_cnt < e) step();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    repeat (4) step();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s pending=%0d required=0", name, q.size());
      q.delete();
    end else begin
      $display("ok   %s all expected changes seen", name);
    end
  endtask

  task automatic check_now(input string name, input logic [2:0] want_rst, input logic want_busy);
    total++;
    if (rst_out !== want_rst || busy !== want_busy) begin
      bad++;
      $display("FAIL %s rst_out=%b busy=%b required rst_out=%b busy=%b", name, rst_out, busy, want_rst, want_busy);
    end else begin
      $display("ok   %s rst_out=%b busy=%b", name, rst_out, busy);
    end
  endtask

  task automatic press_btn(output int t);
    step();
    t = edge_cnt + 1;
    btn_in = 1'b1;
    repeat (PW) step();
    btn_in = 1'b0;
  endtask

  task automatic push_seq(input int e0);
    push(e0 + 16, 3'b110);
    push(e0 + 20, 3'b100);
    push(e0 + 24, 3'b000);
  endtask

  initial begin
    int b, t, d, r;

    // Power-up
    repeat (3) step();
    check_now("reset_state", 3'b111, 1'b1);
    repeat (2) step();
    b = edge_cnt;
    rst = 1'b0;
    push_seq(b + 3);
    drain("powerup");

    // Single press in RUN
    press_btn(t);
    push(t + L, 3'b111);
    push_seq(t + L);
    drain("button_run");

    // Button held for 100 cycles: one sequence only
    step();
    t = edge_cnt + 1;
    btn_in = 1'b1;
    push(t + L, 3'b111);
    push_seq(t + L);
    repeat (100) step();
    btn_in = 1'b0;
    drain("button_hold");
    check_now("after_hold", 3'b000, 1'b0);

`ifdef RST_SEQ_DEBOUNCE_EN
    // Short pulse is filtered out
    step();
    btn_in = 1'b1;
    repeat (5) step();
    btn_in = 1'b0;
    repeat (30) step();
    check_now("short_pulse_ignored", 3'b000, 1'b0);
`endif

    // Lock loss mid-RELEASE, then full sequence on return
    press_btn(t);
    push(t + L, 3'b111);
    push(t + L + 16, 3'b110);
    wait_until(t + L + 17);
    d = edge_cnt + 1;
    locks = 2'b01;
    push(d + 2, 3'b111);
    repeat (10) step();
    check_now("lock_low_held", 3'b111, 1'b1);
    r = edge_cnt + 1;
    locks = 2'b11;
    push_seq(r + 2);
    drain("lock_loss");

    // Press during HOLD is ignored
    step();
    d = edge_cnt + 1;
    locks = 2'b01;
    push(d + 2, 3'b111);
    repeat (5) step();
    press_btn(t);
    repeat (20) step();
    check_now("press_in_hold", 3'b111, 1'b1);
    r = edge_cnt + 1;
    locks = 2'b11;
    push_seq(r + 2);
    drain("hold_press");

    // Async reset between edges during RELEASE
    press_btn(t);
    push(t + L, 3'b111);
    push(t + L + 16, 3'b110);
    wait_until(t + L + 18);
    rst = 1'b1;
    #1;
    check_now("async_rst", 3'b111, 1'b1);
    repeat (3) step();
    b = edge_cnt;
    rst = 1'b0;
    push_seq(b + 3);
    drain("after_async_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
